// File: rtl/lcd_text_formatter.sv
// CO2 reading to 2x16 LCD frame: iterative double-dabble into a shadow digit field,
// committed atomically; the LCD driver reads the committed frame through a 1-cycle port.
module lcd_text_formatter #(
  parameter int VALUE_W  = 16,
  parameter int DIGITS   = 5,
  parameter int BLANK_LZ = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               sample_valid_i,
  input  logic [VALUE_W-1:0] sample_data_i,
  output logic               sample_ready_o,
  input  logic [4:0]         rd_addr_i,
  output logic [7:0]         rd_char_o,
  output logic               frame_busy_o,
  output logic               frame_update_o
);

  localparam logic [127:0] LINE0 = "AIR QUALITY     ";
  localparam logic [127:0] LINE1 = "CO2: ----- ppm  ";

  typedef enum logic [1:0] {IDLE, CONVERT, WRITE, DONE} state_t;

  state_t                  state_q;
  logic [15:0]             bin_q;
  logic [19:0]             bcd_q;
  logic [3:0]              cnt_q;
  logic                    lz_q;
  logic [DIGITS-1:0][7:0]  shadow_q, field_q;
  logic                    ready_q, busy_q, update_q;
  logic [7:0]              rd_char_q, rd_char_d;

  logic [15:0] sample_ext;
  logic [19:0] bcd_adj;
  logic [3:0]  cur_nib;
  logic        blank;
  logic [7:0]  wr_char;

  assign sample_ext = 16'(sample_data_i);

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  // WRITE shifts the BCD register left a nibble per digit, so the MSD is always on top
  assign cur_nib = bcd_q[19:16];
  assign blank   = (BLANK_LZ != 0) && (cur_nib == 4'd0) && lz_q && (cnt_q != 4'd4);
  assign wr_char = blank ? 8'h20 : {4'h3, cur_nib};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      lz_q     <= 1'b1;
      shadow_q <= '0;
      field_q  <= {DIGITS{8'h2D}};
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      update_q <= 1'b0;
    end else begin
      update_q <= 1'b0;
      case (state_q)
        IDLE: if (sample_valid_i && ready_q) begin
          bin_q   <= sample_ext;
          bcd_q   <= '0;
          cnt_q   <= '0;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= CONVERT;
        end
        CONVERT: begin
          {bcd_q, bin_q} <= {bcd_adj[18:0], bin_q, 1'b0};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            cnt_q   <= '0;
            lz_q    <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          shadow_q[cnt_q[2:0]] <= wr_char;
          if (!blank) lz_q <= 1'b0;
          bcd_q <= {bcd_q[15:0], 4'h0};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd4) state_q <= DONE;
        end
        DONE: begin
          field_q  <= shadow_q;
          update_q <= 1'b1;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read mux sees only the committed field, so a read on the commit edge returns the old frame whole
  logic [3:0] ra;
  logic [2:0] di;
  assign ra = rd_addr_i[3:0];
  assign di = 3'(ra - 4'd5);

  always_comb begin
    rd_char_d = 8'h20;
    if (!rd_addr_i[4])               rd_char_d = LINE0[{~ra, 3'b000} +: 8];
    else if (ra >= 4'd5 && ra <= 4'd9) rd_char_d = field_q[di];
    else                             rd_char_d = LINE1[{~ra, 3'b000} +: 8];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_char_q <= 8'h20;
    else       rd_char_q <= rd_char_d;
  end

  assign sample_ready_o = ready_q;
  assign frame_busy_o   = busy_q;
  assign frame_update_o = update_q;
  assign rd_char_o      = rd_char_q;

endmodule
